fetch_pc_unit: RTL

Fetch-stage PC generator and instruction-fetch controller. It owns the architectural fetch PC, presents it to the BTB and instruction memory, and selects the next PC from the BTB prediction or pc+4. It also absorbs execute-stage redirects and hands fetched instructions to decode through a valid/stall interface with a 1-entry skid buffer. It sits directly upstream of the BTB lookup and downstream of branch resolution.

---
 rtl/fetch_pc_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator and instruction-fetch controller.
// It owns the fetch PC, drives the BTB lookup and instruction memory, picks
// the next PC (BTB target or pc+4), absorbs execute redirects, and hands
// instructions to decode through a registered output slot backed by a
// single skid entry.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // BTB lookup
    output logic [31:0] btb_pc_o,
    input  logic        btb_hit_i,
    input  logic [31:0] btb_target_i,
    // instruction memory
    output logic        imem_read_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_i,
    input  logic [31:0] imem_rdata_i,
    // redirect from execute
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    // decode interface
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One fetched instruction with its prediction.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] next;
    } slot_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Redirect target parked while an abandoned read drains. pc_q keeps the
    // old address meanwhile, so the memory sees a stable request until it
    // answers; pc_q picks up the parked target when the drain completes.
    logic [31:0] redir_q, redir_d;
    slot_t       o_q, o_d;
    slot_t       s_q, s_d;

    logic        consume;
    logic [31:0] next_pc;
    logic [31:0] redir_pc;
    slot_t       resp_slot;

    // Memory and BTB always see the current fetch PC.
    assign btb_pc_o    = pc_q;
    assign imem_addr_o = pc_q;
    assign imem_read_o = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

    assign instr_valid_o = o_q.valid;
    assign instr_o       = o_q.instr;
    assign instr_pc_o    = o_q.pc;
    assign pred_taken_o  = o_q.taken;
    assign pred_target_o = o_q.next;

    assign consume  = o_q.valid && !stall_i;
    assign next_pc  = btb_hit_i ? (btb_target_i & ALIGN_MASK) : (pc_q + 32'd4);
    assign redir_pc = redirect_pc_i & ALIGN_MASK;

    // Next-state logic: normal fetch/hold/drain flow, then redirect override.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        o_d     = o_q;
        s_d     = s_q;

        resp_slot       = '0;
        resp_slot.valid = 1'b1;
        resp_slot.instr = imem_rdata_i;
        resp_slot.pc    = pc_q;
        resp_slot.taken = btb_hit_i;
        resp_slot.next  = next_pc;

        if (consume) begin
            o_d.valid = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_resp_i) begin
                    pc_d = next_pc;
                    // S is always empty in FETCH, so a word that cannot
                    // enter O fills S and fetch must pause.
                    if (!o_q.valid || consume) begin
                        o_d = resp_slot;
                    end else begin
                        s_d     = resp_slot;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    o_d       = s_q;
                    s_d.valid = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_resp_i) begin
                    pc_d    = redir_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_i) begin
            o_d.valid = 1'b0;
            s_d.valid = 1'b0;
            redir_d   = redir_pc;
            case (state_q)
                ST_FETCH, ST_DRAIN: begin
                    // A response arriving with the redirect retires the old
                    // read, so the new PC can be fetched immediately.
                    if (imem_resp_i) begin
                        pc_d    = redir_pc;
                        state_d = ST_FETCH;
                    end else begin
                        pc_d    = pc_q;
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    pc_d    = redir_pc;
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State registers; reset clears both slots and restarts at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_A;
            redir_q <= RESET_PC_A;
            o_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            o_q     <= o_d;
            s_q     <= s_d;
        end
    end

endmodule
